// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses around the shared memory port arbiter:
//     - instruction fetch requester   (instr_*)
//     - data load/store requester     (data_*)
//     - single external memory port   (mem_*)
//   Modports:
//     slave  : the arbiter's view (takes requests and memory responses,
//              drives grants, routed responses and the memory request).
//     master : the environment's view (fetch stage, LSU and memory model).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    // Fetch requester
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        instr_flush_i;
    // Load/store requester
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    // Shared memory port
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    modport slave (
        input  instr_req_i, instr_addr_i, instr_flush_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport master (
        output instr_req_i, instr_addr_i, instr_flush_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one req/gnt/rvalid memory port between instruction fetch and
//   data load/store. Grants are combinational; responses return in order
//   and are steered to the issuer using a small tracking FIFO of
//   {owner, discard} entries. Fetch responses outstanding at a flush are
//   absorbed. Data wins contention until STARVE_LIMIT consecutive data
//   grants have been given to a waiting fetch, then fetch wins once.
//   Ports:
//     clk, rstn     : clock, asynchronous active-low reset
//     bus           : instr/data/mem buses (mem_port_arbiter_if.slave)
//     outstanding_o : transactions currently in flight
//     proto_err_o   : sticky, set by an rvalid with nothing in flight
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,  // 1..4
    parameter int STARVE_LIMIT    = 4   // 1..15
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.slave   bus,
    output logic [2:0]          outstanding_o,
    output logic                proto_err_o
);

    localparam logic [2:0] FULL_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [3:0] STARVE_MX = 4'(STARVE_LIMIT);

    // Tracking FIFO, entry 0 is the oldest; owner 1 = data, 0 = instr.
    logic [MAX_OUTSTANDING-1:0] owner_q,   owner_d;
    logic [MAX_OUTSTANDING-1:0] discard_q, discard_d;
    logic [2:0]                 count_q,   count_d;
    logic [3:0]                 starve_q,  starve_d;
    logic                       proto_err_q, proto_err_d;

    logic full, sel_instr, sel_data, push, pop;

    // ---------------- request selection and mux ----------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no branch can leave it unassigned and infer a latch.
        sel_instr       = 1'b0;
        sel_data        = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 32'h0;

        full = (count_q == FULL_CNT);
        if (!full) begin
            sel_instr = bus.instr_req_i &&
                        (!bus.data_req_i || starve_q == STARVE_MX);
            sel_data  = bus.data_req_i && !sel_instr;
        end

        if (sel_instr) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_be_o   = 4'hF;
            bus.mem_addr_o = bus.instr_addr_i;
        end else if (sel_data) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = bus.data_we_i;
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end
    end

    assign bus.instr_gnt_o = sel_instr & bus.mem_gnt_i;
    assign bus.data_gnt_o  = sel_data  & bus.mem_gnt_i;

    assign push = bus.mem_req_o & bus.mem_gnt_i;
    assign pop  = bus.mem_rvalid_i & (count_q != 3'd0);

    // ---------------- response routing ----------------
    // The flush also masks a live fetch response in the same cycle.
    assign bus.data_rvalid_o  = pop & owner_q[0];
    assign bus.instr_rvalid_o = pop & ~owner_q[0] & ~discard_q[0] & ~bus.instr_flush_i;
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;
    assign bus.instr_err_o    = bus.mem_err_i;
    assign bus.data_err_o     = bus.mem_err_i;

    // ---------------- FIFO / starvation / protocol next state ----------------
    always_comb begin
        owner_d     = owner_q;
        discard_d   = discard_q;
        count_d     = count_q;
        starve_d    = starve_q;
        proto_err_d = proto_err_q | (bus.mem_rvalid_i & (count_q == 3'd0));

        // Mark only entries already in flight; a fetch pushed this cycle
        // is the new-PC fetch and must survive.
        if (bus.instr_flush_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (i < int'(count_q) && !owner_q[i]) discard_d[i] = 1'b1;
            end
        end

        if (pop) begin
            owner_d   = owner_d >> 1;
            discard_d = discard_d >> 1;
            count_d   = count_d - 3'd1;
        end

        // Push lands after the pop shift, at the first free slot.
        if (push) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (i == int'(count_d)) begin
                    owner_d[i]   = sel_data;
                    discard_d[i] = 1'b0;
                end
            end
            count_d = count_d + 3'd1;
        end

        if (!bus.instr_req_i || bus.instr_gnt_o) begin
            starve_d = 4'd0;
        end else if (bus.data_gnt_o && starve_q != STARVE_MX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the FIFO storage is reset as well; count alone defines
            // validity, but clearing it keeps X out of the steered rvalids.
            owner_q     <= '0;
            discard_q   <= '0;
            count_q     <= 3'd0;
            starve_q    <= 4'd0;
            proto_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above.
            owner_q     <= owner_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign outstanding_o = count_q;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: a directed vector table (single fetch,
//   contention/starvation, mixed ordering), hand-written multi-cycle
//   sequences (full back-pressure, protocol error and reset, flush discard
//   on a 3-deep instance) and a random run against a queue-based model.
//   Inputs change just after the rising edge; outputs are sampled at the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MAX_OUT = 2;
    localparam int LIMIT   = 4;
    localparam logic [31:0] D_ADDR  = 32'h0000_2000;
    localparam logic [31:0] D_WDATA = 32'h55AA_0000;

    logic       clk;
    logic       rstn;
    logic [2:0] outstanding, outstanding3;
    logic       proto_err, proto_err3;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus3 ();

    mem_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .outstanding_o(outstanding), .proto_err_o(proto_err)
    );

    mem_port_arbiter #(.MAX_OUTSTANDING(3), .STARVE_LIMIT(LIMIT)) dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3),
        .outstanding_o(outstanding3), .proto_err_o(proto_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic err, input logic flush);
        bus.instr_req_i   = ireq;
        bus.instr_addr_i  = iaddr;
        bus.instr_flush_i = flush;
        bus.data_req_i    = dreq;
        bus.data_we_i     = dwe;
        bus.data_be_i     = dbe;
        bus.data_addr_i   = daddr;
        bus.data_wdata_i  = dwdata;
        bus.mem_gnt_i     = gnt;
        bus.mem_rvalid_i  = rv;
        bus.mem_rdata_i   = rdata;
        bus.mem_err_i     = err;
    endtask

    // Fetch-only traffic on the 3-deep instance.
    task automatic drive3(input logic ireq, input logic [31:0] iaddr, input logic gnt,
                          input logic rv, input logic [31:0] rdata, input logic flush);
        bus3.instr_req_i   = ireq;
        bus3.instr_addr_i  = iaddr;
        bus3.instr_flush_i = flush;
        bus3.data_req_i    = 1'b0;
        bus3.data_we_i     = 1'b0;
        bus3.data_be_i     = 4'h0;
        bus3.data_addr_i   = 32'h0;
        bus3.data_wdata_i  = 32'h0;
        bus3.mem_gnt_i     = gnt;
        bus3.mem_rvalid_i  = rv;
        bus3.mem_rdata_i   = rdata;
        bus3.mem_err_i     = 1'b0;
    endtask

    // Shorthands for the common cases on the main instance.
    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic        e_igt;
        logic        e_dgt;
        logic        e_irv;
        logic        e_drv;
        logic [2:0]  e_out;
    } vec_t;

    function automatic vec_t v(logic ireq, logic [31:0] iaddr, logic dreq, logic gnt,
                               logic rv, logic [31:0] rdata, logic err,
                               logic e_mreq, logic [31:0] e_addr, logic e_we, logic [3:0] e_be,
                               logic e_igt, logic e_dgt, logic e_irv, logic e_drv,
                               logic [2:0] e_out);
        vec_t r;
        r.ireq = ireq; r.iaddr = iaddr; r.dreq = dreq; r.gnt = gnt;
        r.rv = rv; r.rdata = rdata; r.err = err;
        r.e_mreq = e_mreq; r.e_addr = e_addr; r.e_we = e_we; r.e_be = e_be;
        r.e_igt = e_igt; r.e_dgt = e_dgt; r.e_irv = e_irv; r.e_drv = e_drv;
        r.e_out = e_out;
        return r;
    endfunction

    vec_t tbl[$];

    // ---------------- random reference model ----------------
    typedef struct {
        bit owner;    // 1 = data
        bit discard;
    } ent_t;

    ent_t mq[$];
    int   m_starve;
    bit   m_proto;

    initial begin
        rstn = 1'b0;
        idle();
        drive3(0, 0, 0, 0, 0, 0);

        // Single fetch
        tbl.push_back(v(1, 32'h100, 0, 1, 0, 0, 0,           1, 32'h100, 0, 4'hF, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0,       0, 0, 0, 0, 0,           0, 0,       0, 4'h0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0,       0, 0, 1, 32'hDEADBEEF, 0, 0, 0,      0, 4'h0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0,       0, 0, 0, 0, 0,           0, 0,       0, 4'h0, 0, 0, 0, 0, 0));
        // Contention: D D D D I D D D D I, each response returned a cycle later
        tbl.push_back(v(1, 32'h300, 1, 1, 0, 0, 0,           1, D_ADDR,  1, 4'h3, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1, 32'h300, 1, 1, 1, 32'h11, 0,  1, D_ADDR,  1, 4'h3, 0, 1, 0, 1, 1));
        tbl.push_back(v(1, 32'h300, 1, 1, 1, 32'h12, 0,      1, 32'h300, 0, 4'hF, 1, 0, 0, 1, 1));
        tbl.push_back(v(1, 32'h300, 1, 1, 1, 32'h13, 0,      1, D_ADDR,  1, 4'h3, 0, 1, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1, 32'h300, 1, 1, 1, 32'h14, 0,  1, D_ADDR,  1, 4'h3, 0, 1, 0, 1, 1));
        tbl.push_back(v(1, 32'h300, 1, 1, 1, 32'h15, 0,      1, 32'h300, 0, 4'hF, 1, 0, 0, 1, 1));
        tbl.push_back(v(0, 0,       0, 0, 1, 32'h16, 0,      0, 0,       0, 4'h0, 0, 0, 1, 0, 1));
        // Mixed ordering I, D, I with errors {0,1,0}
        tbl.push_back(v(1, 32'h400, 0, 1, 0, 0, 0,           1, 32'h400, 0, 4'hF, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0,       1, 1, 0, 0, 0,           1, D_ADDR,  1, 4'h3, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0,       0, 0, 1, 32'hA1, 0,      0, 0,       0, 4'h0, 0, 0, 1, 0, 2));
        tbl.push_back(v(1, 32'h404, 0, 1, 1, 32'hA2, 1,      1, 32'h404, 0, 4'hF, 1, 0, 0, 1, 1));
        tbl.push_back(v(0, 0,       0, 0, 1, 32'hA3, 0,      0, 0,       0, 4'h0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0,       0, 0, 0, 0, 0,           0, 0,       0, 4'h0, 0, 0, 0, 0, 0));

        tick(); tick();
        rstn = 1'b1;
        tick();

        // Reset state
        #4;
        check("reset_state",
              {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.instr_gnt_o,
               bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o, outstanding, proto_err},
              '0);
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, 1'b1, 4'h3, D_ADDR, D_WDATA,
                  tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err, 1'b0);
            #4;
            check($sformatf("tbl[%0d] mem_req", i),
                  {bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o},
                  {tbl[i].e_mreq, tbl[i].e_addr, tbl[i].e_we, tbl[i].e_be,
                   (tbl[i].e_mreq && tbl[i].e_we) ? D_WDATA : 32'h0});
            check($sformatf("tbl[%0d] gnt", i), {bus.instr_gnt_o, bus.data_gnt_o},
                  {tbl[i].e_igt, tbl[i].e_dgt});
            check($sformatf("tbl[%0d] rvalid", i), {bus.instr_rvalid_o, bus.data_rvalid_o},
                  {tbl[i].e_irv, tbl[i].e_drv});
            check($sformatf("tbl[%0d] outstanding", i), outstanding, tbl[i].e_out);
            check($sformatf("tbl[%0d] rdata_err", i),
                  {bus.instr_rdata_o, bus.data_rdata_o, bus.instr_err_o, bus.data_err_o},
                  {tbl[i].rdata, tbl[i].rdata, tbl[i].err, tbl[i].err});
            tick();
        end

        // ---------------- full back-pressure ----------------
        drive(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #4;
        check("full_g1", {bus.instr_gnt_o, outstanding}, {1'b1, 3'd0}); tick();
        drive(1, 32'h504, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #4;
        check("full_g2", {bus.instr_gnt_o, outstanding}, {1'b1, 3'd1}); tick();
        drive(1, 32'h508, 0, 0, 0, 0, 0, 1, 1, 32'h77, 0, 0); #4;
        check("full_block", {bus.mem_req_o, bus.instr_gnt_o, bus.instr_rvalid_o, outstanding},
              {1'b0, 1'b0, 1'b1, 3'd2}); tick();
        drive(1, 32'h508, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #4;
        check("full_reissue", {bus.mem_req_o, bus.mem_addr_o, bus.instr_gnt_o, outstanding},
              {1'b1, 32'h508, 1'b1, 3'd1}); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h78, 0, 0); #4;
        check("full_drain1", {bus.instr_rvalid_o, outstanding}, {1'b1, 3'd2}); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h79, 0, 0); #4;
        check("full_drain2", {bus.instr_rvalid_o, outstanding}, {1'b1, 3'd1}); tick();
        idle(); #4;
        check("full_empty", outstanding, 3'd0); tick();

        // ---------------- protocol error and reset ----------------
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0); #4;
        check("proto_rvalids", {bus.instr_rvalid_o, bus.data_rvalid_o, proto_err}, 3'b000); tick();
        idle(); #4;
        check("proto_set", proto_err, 1'b1); tick();
        #4;
        check("proto_held", proto_err, 1'b1); tick();
        drive(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #4;
        check("proto_grant", bus.instr_gnt_o, 1'b1); tick();
        idle(); #4;
        check("pre_reset", {outstanding, proto_err}, {3'd1, 1'b1});
        rstn = 1'b0;
        #1;
        check("async_reset", {outstanding, proto_err}, {3'd0, 1'b0});
        #1;
        rstn = 1'b1;
        tick();
        // The entry granted before reset is gone, so its response is unexpected.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9A, 0, 0); #4;
        check("lost_rvalid", {bus.instr_rvalid_o, bus.data_rvalid_o}, 2'b00); tick();
        idle(); #4;
        check("lost_proto", proto_err, 1'b1); tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // ---------------- flush discard (3-deep instance) ----------------
        drive3(1, 32'h180, 1, 0, 0, 0); #4;
        check("fl_g1", {bus3.instr_gnt_o, outstanding3}, {1'b1, 3'd0}); tick();
        drive3(1, 32'h184, 1, 0, 0, 0); #4;
        check("fl_g2", {bus3.instr_gnt_o, outstanding3}, {1'b1, 3'd1}); tick();
        drive3(1, 32'h200, 1, 0, 0, 1); #4;
        check("fl_newpc", {bus3.mem_req_o, bus3.mem_addr_o, bus3.instr_gnt_o, outstanding3},
              {1'b1, 32'h200, 1'b1, 3'd2}); tick();
        drive3(0, 0, 0, 1, 32'h1, 0); #4;
        check("fl_drop1", {bus3.instr_rvalid_o, outstanding3}, {1'b0, 3'd3}); tick();
        drive3(0, 0, 0, 1, 32'h2, 0); #4;
        check("fl_drop2", {bus3.instr_rvalid_o, outstanding3}, {1'b0, 3'd2}); tick();
        drive3(0, 0, 0, 1, 32'hCAFE, 0); #4;
        check("fl_keep", {bus3.instr_rvalid_o, bus3.instr_rdata_o, outstanding3},
              {1'b1, 32'hCAFE, 3'd1}); tick();
        drive3(1, 32'h300, 1, 0, 0, 0); #4;
        check("fl_g3", {bus3.instr_gnt_o, outstanding3}, {1'b1, 3'd0}); tick();
        drive3(0, 0, 0, 1, 32'h3, 1); #4;
        check("fl_same_cycle", {bus3.instr_rvalid_o, outstanding3, proto_err3},
              {1'b0, 3'd1, 1'b0}); tick();
        drive3(0, 0, 0, 0, 0, 0); #4;
        check("fl_empty", outstanding3, 3'd0); tick();

        // ---------------- random run against the model ----------------
        mq.delete();
        m_starve = 0;
        m_proto  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        ireq, dreq, dwe, gnt, rv, err, flush;
            logic [3:0]  dbe;
            logic [31:0] iaddr, daddr, dwdata, rdata;
            bit          full, si, sd, pop, e_irv, e_drv;
            logic [69:0] e_mem;

            ireq   = ($urandom_range(99) < 60);
            dreq   = ($urandom_range(99) < 60);
            dwe    = 1'($urandom);
            dbe    = 4'($urandom);
            iaddr  = $urandom;
            daddr  = $urandom;
            dwdata = $urandom;
            gnt    = ($urandom_range(99) < 70);
            rv     = (mq.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 3);
            rdata  = $urandom;
            err    = ($urandom_range(99) < 10);
            flush  = ($urandom_range(99) < 10);
            drive(ireq, iaddr, dreq, dwe, dbe, daddr, dwdata, gnt, rv, rdata, err, flush);
            #4;

            full  = (mq.size() == MAX_OUT);
            si    = !full && ireq && (!dreq || m_starve == LIMIT);
            sd    = !full && dreq && !si;
            e_mem = si ? {1'b1, 1'b0, 4'hF, iaddr, 32'h0} :
                    sd ? {1'b1, dwe, dbe, daddr, dwdata} : 70'h0;
            pop   = rv && mq.size() > 0;
            e_irv = pop && !mq[0].owner && !mq[0].discard && !flush;
            e_drv = pop && mq[0].owner;

            check($sformatf("rnd[%0d] mem", c),
                  {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
                  e_mem);
            check($sformatf("rnd[%0d] rsp", c),
                  {bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o,
                   outstanding, proto_err, bus.data_err_o},
                  {si && gnt, sd && gnt, e_irv, e_drv, 3'(mq.size()), m_proto, err});

            // Advance the model across the clock edge.
            if (rv && mq.size() == 0) m_proto = 1'b1;
            if (flush) foreach (mq[k]) if (!mq[k].owner) mq[k].discard = 1'b1;
            if (pop) void'(mq.pop_front());
            if ((si || sd) && gnt) mq.push_back('{owner: sd, discard: 1'b0});
            if (!ireq || (si && gnt)) m_starve = 0;
            else if (sd && gnt && m_starve < LIMIT) m_starve++;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared req/gnt/rvalid memory port between the instruction fetch requester and the data load/store requester, with in-order outstanding-transaction tracking. Sits between the fetch stage / load-store unit and the single external memory interface. Each response is routed back to the requester that issued it. Instruction responses still in flight when a fetch flush occurs are absorbed and never reach the fetch stage.

## Interface

Parameters:
- `MAX_OUTSTANDING`, default 2: maximum number of granted transactions awaiting `mem_rvalid_i`. Range 1..4.
- `STARVE_LIMIT`, default 4: number of consecutive data grants, while instruction requests are pending, after which the instruction port gets priority. Range 1..15.

Ports:
- Clock and reset: clock `clk`; reset `rstn`, asynchronous, active-low.
- `instr_req_i` in 1: fetch request (read only).
- `instr_addr_i` in 32: fetch address; bits [1:0] are forwarded unchanged.
- `instr_gnt_o` out 1: fetch request accepted this cycle.
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out 32: fetch read data.
- `instr_err_o` out 1: fetch bus error; qualified by `instr_rvalid_o`.
- `instr_flush_i` in 1: discard all outstanding fetch responses.
- `data_req_i` in 1: load/store request.
- `data_we_i` in 1: 1 = store.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: data address.
- `data_wdata_i` in 32: store data.
- `data_gnt_o` out 1: data request accepted.
- `data_rvalid_o` out 1: data response valid.
- `data_rdata_o` out 32: load data.
- `data_err_o` out 1: data bus error.
- `mem_req_o` out 1: shared-port request.
- `mem_we_o` out 1: shared-port write enable.
- `mem_be_o` out 4: shared-port byte enables.
- `mem_addr_o` out 32: shared-port address.
- `mem_wdata_o` out 32: shared-port write data.
- `mem_gnt_i` in 1: memory accepts the request.
- `mem_rvalid_i` in 1: memory response valid.
- `mem_rdata_i` in 32: memory read data.
- `mem_err_i` in 1: memory bus error.
- `outstanding_o` out 3: current number of transactions in flight.
- `proto_err_o` out 1: sticky flag; set when `mem_rvalid_i` arrives with nothing in flight.

## Operation

- Tracking FIFO: `MAX_OUTSTANDING` entries, each holding {owner: 0=instr / 1=data, discard}.
  - Push on `mem_req_o & mem_gnt_i`.
  - Pop on `mem_rvalid_i` when non-empty.
  - A push and a pop in the same cycle are both applied; the count is unchanged.
- Full: when count == `MAX_OUTSTANDING`, `mem_req_o`=0 and both gnts are 0, even if `mem_rvalid_i` is 1 that cycle.
- Selection when not full:
  - Only one requester active: select it.
  - Both active: select data, unless `starve_cnt` == `STARVE_LIMIT`, in which case select instr.
- `starve_cnt` (4 bits):
  - Increments on a data grant while `instr_req_i`=1.
  - Clears on any instr grant, and when `instr_req_i`=0.
  - Saturates at `STARVE_LIMIT`.
- Mux: `mem_*` request fields come from the selected requester. The instr side drives `we`=0 and `be`=4'hF. When nothing is selected, `mem_req_o`=0 and the other `mem_*` request fields are 0.
- Grant: `instr_gnt_o` = sel_instr & `mem_gnt_i`; `data_gnt_o` = sel_data & `mem_gnt_i`. Both are combinational.
- Response routing, using the head entry while `mem_rvalid_i`=1:
  - Owner data: `data_rvalid_o`=1.
  - Owner instr and discard=0: `instr_rvalid_o`=1.
  - Owner instr and discard=1: the response is dropped; the entry is still popped.
  - rdata/err outputs pass `mem_rdata_i`/`mem_err_i` directly to both sides; only the rvalids are steered.
- Flush:
  - `instr_flush_i`=1 sets discard on every valid instr entry at the clock edge.
  - It also suppresses `instr_rvalid_o` combinationally in the flush cycle.
  - An instr entry pushed in the flush cycle itself is not discarded (new-PC fetch).
  - Data entries are never affected.
- Unexpected rvalid (FIFO empty): `proto_err_o` is set and held until reset; no rvalid is forwarded.

## Timing

- Request path (req -> `mem_req_o`, `mem_gnt_i` -> requester gnt): zero-cycle combinational.
- Response path (`mem_rvalid_i` -> requester rvalid): zero-cycle combinational from the registered FIFO head.
- FIFO, discard bits, `starve_cnt` and `proto_err_o` update at the rising clk edge.
- Reset (asynchronous): FIFO empty, `starve_cnt`=0, `proto_err_o`=0.
  - Consequently `outstanding_o`=0, `mem_req_o`=0, all gnt/rvalid outputs 0 and `mem_*` request fields 0 while no requests are active.
- Reset mid-transaction: in-flight entries are lost. Later `mem_rvalid_i` pulses set `proto_err_o`.
- Requesters must hold req/addr/data stable until gnt. The block does not latch request fields.

## Test plan

- Single fetch: `instr_req_i`=1, addr 0x100; mem grants in cycle 0 and returns rvalid with 0xDEADBEEF in cycle 2.
  - Required: `instr_gnt_o`=1 in cycle 0; `instr_rvalid_o`=1 with 0xDEADBEEF in cycle 2; `outstanding_o` goes 0 -> 1 -> 0.
- Contention and starvation: `STARVE_LIMIT`=4; both requesters held high; mem grants every cycle.
  - Required: grant order D D D D I D D D D I…
  - Required: `mem_we_o`/`mem_be_o` track the data request during data grants; during instr grants they are 0/4'hF.
- Full back-pressure: `MAX_OUTSTANDING`=2; two grants issued with no rvalid.
  - Required: the third cycle has `mem_req_o`=0 even with `mem_rvalid_i`=1 that cycle.
  - Required: the request reissues the next cycle (count now 1).
- Flush discard: two instr transactions outstanding; pulse `instr_flush_i`; the same cycle grants an instr request to 0x200.
  - Required: the next two rvalids produce no `instr_rvalid_o`.
  - Required: the third rvalid (the 0x200 fetch) produces `instr_rvalid_o`=1.
- Mixed ordering: issue I, D, I; return three rvalids with errors {0,1,0}.
  - Required: rvalids appear in order instr, data, instr.
  - Required: `data_err_o`=1 on the second response only.
- Protocol error and reset: pulse `mem_rvalid_i` with nothing outstanding.
  - Required: `proto_err_o`=1 from the next cycle and held; all rvalid outputs stay 0.
  - Required: asserting `rstn`=0 clears `proto_err_o` and `outstanding_o` asynchronously.
